// File: rtl/seq_pkg.sv
// Shared types and constants for the fetch sequencer.
// State encoding, branch-group opcodes and the NOP word.
package seq_pkg;

  // EXEC is DECODE with the top bit set.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_LOAD   = 3'b010,
    S_DECODE = 3'b011,
    S_EXEC   = 3'b111
  } state_e;

  localparam logic [4:0]  BR_GRP = 5'b10000;
  localparam logic [2:0]  OP_JMP = 3'd0;
  localparam logic [2:0]  OP_JZE = 3'd1;
  localparam logic [2:0]  OP_JNE = 3'd2;
  localparam logic [2:0]  OP_JCY = 3'd3;
  localparam logic [2:0]  OP_RET = 3'd4;
  localparam logic [2:0]  OP_BSR = 3'd5;
  localparam logic [23:0] NOP    = 24'h080000;

  function automatic logic is_branch(input logic [23:0] ir);
    return (ir[23:19] == BR_GRP) && (ir[18:15] == 4'd0);
  endfunction

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// Hardware return stack (LIFO) for BSR/RET.
// Overflowing pushes are dropped; err is sticky until reset.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [W-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  top_idx;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign err     = err_q;
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign dout    = mem_q[top_idx];

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (push) begin
      if (full) err_d = 1'b1;
      else      sp_d  = sp_q + SPW'(1);
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else       sp_d  = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[sp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and program sequencer.
// Four-phase FETCH/LOAD/DECODE/EXEC cycle with branch resolution.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W        = 12,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [23:0]     pm_data,
  input  logic            z_flag,
  input  logic            cy_flag,
  input  logic            stall,
  output logic [23:0]     IR,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc,
  output logic            stack_err,
  output logic [1:0]      seq_state
);

  state_e          state_q, state_d;
  logic [23:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, tgt, st_top;
  logic [2:0]      op;
  logic            exec_adv;
  logic            st_push, st_pop;
  logic            st_full, st_empty;

  assign pm_addr   = pc_q;
  assign pc        = pc_q;
  assign IR        = ir_q;
  assign pm_rd     = (state_q == S_FETCH);
  assign ir_valid  = (state_q == S_DECODE);
  assign seq_state = state_q[2] ? 2'd0 : state_q[1:0];

  assign exec_adv = (state_q == S_EXEC) && !stall;
  assign pc_inc   = pc_q + PC_W'(1);
  assign tgt      = ir_q[PC_W-1:0];
  assign op       = ir_q[14:12];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (!stall) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ir_d = (state_q == S_LOAD) ? pm_data : ir_q;

  // Flags are only looked at on the edge that leaves EXEC.
  always_comb begin
    pc_d    = pc_q;
    st_push = 1'b0;
    st_pop  = 1'b0;
    if (exec_adv) begin
      pc_d = pc_inc;
      if (is_branch(ir_q)) begin
        case (op)
          OP_JMP: pc_d = tgt;
          OP_JZE: if (z_flag)  pc_d = tgt;
          OP_JNE: if (!z_flag) pc_d = tgt;
          OP_JCY: if (cy_flag) pc_d = tgt;
          OP_RET: begin
            st_pop = 1'b1;
            if (!st_empty) pc_d = st_top;
          end
          OP_BSR: begin
            st_push = 1'b1;
            pc_d    = tgt;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= NOP;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (st_push),
    .pop   (st_pop),
    .din   (pc_inc),
    .dout  (st_top),
    .full  (st_full),
    .empty (st_empty),
    .err   (stack_err)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer.
// Program memory and a queue-based sequencer model live here.
module tb_fetch_sequencer;

  localparam logic [23:0] NOPW = 24'h080000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pm_addr;
  logic        pm_rd;
  logic [23:0] pm_data = '0;
  logic        z_flag = 1'b0;
  logic        cy_flag = 1'b0;
  logic        stall = 1'b0;
  logic [23:0] IR;
  logic        ir_valid;
  logic [11:0] pc;
  logic        stack_err;
  logic [1:0]  seq_state;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .pm_addr   (pm_addr),
    .pm_rd     (pm_rd),
    .pm_data   (pm_data),
    .z_flag    (z_flag),
    .cy_flag   (cy_flag),
    .stall     (stall),
    .IR        (IR),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .stack_err (stack_err),
    .seq_state (seq_state)
  );

  logic [23:0] pm [4096];

  always @(posedge clk) if (pm_rd) pm_data <= pm[pm_addr];

  int ncmp = 0;
  int nerr = 0;

  logic [11:0] m_pc;
  logic [11:0] m_stk[$];
  bit          m_err;

  typedef struct {
    logic [11:0] at;
    logic [23:0] ins;
    bit          z;
    bit          c;
    logic [11:0] nxt;
    bit          err;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] br(input int op, input logic [11:0] t);
    logic [2:0] o;
    o = 3'(op);
    return {5'b10000, 4'b0000, o, t};
  endfunction

  task automatic clr_pm();
    for (int i = 0; i < 4096; i++) pm[i] = NOPW;
  endtask

  // Architectural effect of one instruction, from the ISA rules.
  task automatic model_step(input bit z, input bit c);
    logic [23:0] ins;
    logic [11:0] inc;
    logic [11:0] tg;
    ins = pm[m_pc];
    inc = m_pc + 12'd1;
    tg  = ins[11:0];
    if (ins[23:15] != 9'b100000000) m_pc = inc;
    else begin
      case (ins[14:12])
        3'd0: m_pc = tg;
        3'd1: m_pc = z ? tg : inc;
        3'd2: m_pc = !z ? tg : inc;
        3'd3: m_pc = c ? tg : inc;
        3'd4: begin
          if (m_stk.size() == 0) begin
            m_err = 1'b1;
            m_pc  = inc;
          end else m_pc = m_stk.pop_back();
        end
        3'd5: begin
          if (m_stk.size() == 8) m_err = 1'b1;
          else m_stk.push_back(inc);
          m_pc = tg;
        end
        default: m_pc = inc;
      endcase
    end
  endtask

  // Holds reset, checks reset outputs, releases and walks to DECODE.
  task automatic do_reset_start();
    reset = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pm_rd", pm_rd, 0);
    chk("rst_ir", IR, NOPW);
    chk("rst_addr", pm_addr, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_valid", ir_valid, 0);
    reset = 1'b0;
    m_pc  = 12'h000;
    m_stk.delete();
    m_err = 1'b0;
    chk("idle_pm_rd", pm_rd, 0);
    @(negedge clk);
    chk("first_rd", pm_rd, 1);
    chk("first_addr", pm_addr, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Entered at the DECODE negedge; leaves at the next DECODE negedge.
  task automatic exec_instr(input int nst, input bit z, input bit c);
    chk("dec_valid", ir_valid, 1);
    chk("dec_ir", IR, pm[m_pc]);
    chk("dec_pc", pc, m_pc);
    chk("dec_err", stack_err, m_err);
    chk("dec_state", seq_state, 3);
    model_step(z, c);
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      stall   = 1'b1;
      z_flag  = (i % 2 == 0) ? ~z : z;
      cy_flag = (i % 2 == 0) ? ~c : c;
    end
    @(negedge clk);
    stall   = 1'b0;
    z_flag  = z;
    cy_flag = c;
    chk("exec_state", seq_state, 0);
    @(negedge clk);
    chk("fetch_rd", pm_rd, 1);
    chk("fetch_addr", pm_addr, m_pc);
    chk("fetch_valid", ir_valid, 0);
    @(negedge clk);
    chk("load_valid", ir_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    clr_pm();
    tv[0]  = '{12'h010, br(1, 12'h050), 1'b1, 1'b0, 12'h050, 1'b0};
    tv[1]  = '{12'h010, br(1, 12'h050), 1'b0, 1'b1, 12'h011, 1'b0};
    tv[2]  = '{12'h010, br(2, 12'h050), 1'b0, 1'b0, 12'h050, 1'b0};
    tv[3]  = '{12'h010, br(2, 12'h050), 1'b1, 1'b0, 12'h011, 1'b0};
    tv[4]  = '{12'h010, br(3, 12'h050), 1'b0, 1'b1, 12'h050, 1'b0};
    tv[5]  = '{12'h010, br(3, 12'h050), 1'b1, 1'b0, 12'h011, 1'b0};
    tv[6]  = '{12'h010, br(0, 12'h123), 1'b0, 1'b0, 12'h123, 1'b0};
    tv[7]  = '{12'h010, br(6, 12'h050), 1'b1, 1'b1, 12'h011, 1'b0};
    tv[8]  = '{12'h010, br(7, 12'h050), 1'b1, 1'b1, 12'h011, 1'b0};
    tv[9]  = '{12'h010, 24'h808050,     1'b1, 1'b1, 12'h011, 1'b0};
    tv[10] = '{12'hFFF, NOPW,           1'b0, 1'b0, 12'h000, 1'b0};
    tv[11] = '{12'h030, br(4, 12'h000), 1'b0, 1'b0, 12'h031, 1'b1};

    #1 reset = 1'b1;

    // Straight-line NOPs.
    do_reset_start();
    for (int i = 0; i < 3; i++) exec_instr(0, 1'b0, 1'b0);
    chk("line_pc", pc, 12'h003);

    // Single-instruction vectors reached via a JMP from 000.
    for (int i = 0; i < 12; i++) begin
      clr_pm();
      pm[0]        = br(0, tv[i].at);
      pm[tv[i].at] = tv[i].ins;
      do_reset_start();
      exec_instr(0, 1'b0, 1'b0);
      exec_instr(0, tv[i].z, tv[i].c);
      chk("tbl_pc", pc, tv[i].nxt);
      chk("tbl_err", stack_err, tv[i].err);
    end

    // JZE held in EXEC by stall, flags toggling.
    clr_pm();
    pm[12'h000] = br(1, 12'h050);
    pm[12'h050] = br(1, 12'h070);
    do_reset_start();
    exec_instr(3, 1'b1, 1'b0);
    chk("stall_taken", pc, 12'h050);
    exec_instr(3, 1'b0, 1'b0);
    chk("stall_not_taken", pc, 12'h051);

    // BSR / RET pair.
    clr_pm();
    pm[12'h000] = br(0, 12'h020);
    pm[12'h020] = br(5, 12'h100);
    pm[12'h100] = br(4, 12'h000);
    do_reset_start();
    exec_instr(0, 1'b0, 1'b0);
    exec_instr(0, 1'b0, 1'b0);
    chk("bsr_pc", pc, 12'h100);
    exec_instr(0, 1'b0, 1'b0);
    chk("ret_pc", pc, 12'h021);
    chk("ret_err", stack_err, 0);

    // Nine nested BSRs, nine RETs.
    clr_pm();
    pm[12'h000] = br(0, 12'h200);
    for (int k = 0; k < 9; k++)
      pm[12'h200 + 16 * k] = br(5, 12'(12'h200 + 16 * (k + 1)));
    pm[12'h290] = br(4, 12'h000);
    for (int k = 0; k < 8; k++) pm[12'h201 + 16 * k] = br(4, 12'h000);
    pm[12'h202] = br(0, 12'h345);
    do_reset_start();
    for (int i = 0; i < 9; i++) exec_instr(0, 1'b0, 1'b0);
    chk("deep8_err", stack_err, 0);
    exec_instr(0, 1'b0, 1'b0);
    chk("ovf_pc", pc, 12'h290);
    chk("ovf_err", stack_err, 1);
    exec_instr(0, 1'b0, 1'b0);
    chk("ret9_pc", pc, 12'h271);
    for (int i = 0; i < 8; i++) exec_instr(0, 1'b0, 1'b0);
    chk("unwind_pc", pc, 12'h202);

    // Reset while in EXEC.
    @(negedge clk);
    stall = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_rd", pm_rd, 0);
    chk("midrst_ir", IR, NOPW);
    chk("midrst_addr", pm_addr, 0);
    chk("midrst_err", stack_err, 0);
    chk("midrst_state", seq_state, 0);
    do_reset_start();
    exec_instr(0, 1'b0, 1'b0);

    // Random programs against the model.
    for (int i = 0; i < 4096; i++) begin
      if ($urandom % 2 == 1) pm[i] = br($urandom % 8, 12'($urandom));
      else pm[i] = 24'($urandom);
    end
    do_reset_start();
    for (int n = 0; n < 300; n++)
      exec_instr($urandom % 3, 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and program sequencer that sits directly upstream of the microinstruction ROM stage. It owns the program counter, reads 24-bit instructions from a synchronous program memory, and presents them on `IR` to the decode stage. It resolves control-flow instructions (JMP/JZE/JNE/JCY/BSR/RET) using ALU flags and a hardware return stack. Each instruction follows a fixed four-phase cycle that the decode stage and datapath align to.

## Interface
- `PC_W`, 12: program counter / branch target width, taken from IR[11:0]
- `STACK_DEPTH`, 8: return stack entries, power of two
- `RESET_PC`, 12'h000: PC value after reset
- `clk` in 1: single system clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `pm_addr` out PC_W: program memory address, equal to the current PC
- `pm_rd` out 1: program memory read strobe
- `pm_data` in 24: program memory read data, valid the cycle after `pm_rd`
- `z_flag` in 1: ALU zero flag, sampled in EXEC
- `cy_flag` in 1: ALU carry flag, sampled in EXEC
- `stall` in 1: datapath busy; holds the sequencer in EXEC
- `IR` out 24: current instruction register
- `ir_valid` out 1: one-cycle pulse in DECODE, indicating `IR` holds a new instruction
- `pc` out PC_W: current program counter
- `stack_err` out 1: sticky flag for return stack overflow/underflow
- `seq_state` out 2: current state, for debug

## Operation
- **States:** IDLE(0), FETCH(1), LOAD(2), DECODE(3). EXEC is encoded as DECODE plus the `exec` bit. The state register is 3 bits, and `seq_state` reports {FETCH=1, LOAD=2, DECODE=3, EXEC=0} once running.
- **Transitions:**
  - IDLE→FETCH (exactly once after reset)
  - FETCH→LOAD
  - LOAD→DECODE
  - DECODE→EXEC
  - EXEC→FETCH when `stall`=0; otherwise EXEC holds.
- **FETCH:** `pm_rd`=1. `pm_addr`=PC.
- **LOAD:** `IR` ← `pm_data` at the end of the cycle.
- **DECODE:** `ir_valid`=1. The downstream stage latches `IR` at the end of this cycle.
- **EXEC:** the next PC is computed from `IR`, `z_flag`, `cy_flag` and the stack. It is registered at the final EXEC edge, when `stall`=0.
- **Branch group:** IR[23:19]==5'b10000 and IR[18:15]==0. The op is IR[14:12], and the target is IR[11:0].
  - 0 JMP: PC←target.
  - 1 JZE: PC←target if z=1, else PC+1.
  - 2 JNE: PC←target if z=0, else PC+1.
  - 3 JCY: PC←target if cy=1, else PC+1.
  - 4 RET: PC←pop.
  - 5 BSR: push PC+1, then PC←target.
  - 6, 7 (memory moves) and every other instruction: PC←PC+1.
- **PC arithmetic:** modulo 2^PC_W. 12'hFFF+1 = 12'h000, including the return address pushed by BSR.
- **Return stack:** `sp` counts 0..STACK_DEPTH.
  - BSR with sp==STACK_DEPTH: the push is dropped, `stack_err`←1, and the branch is still taken.
  - RET with sp==0: `stack_err`←1, and PC←PC+1.
- **`stack_err`:** clears only on reset.
- **Flags and stall:** flags are sampled only on the EXEC edge that advances the state. Flag changes during stall cycles have no effect.

## Timing
- **Reset values:** state=IDLE, PC=RESET_PC, IR=24'h080000 (NOP), sp=0, `stack_err`=0, `pm_rd`=0, `ir_valid`=0. Stack contents are don't-care.
- **Reset mid-instruction:** state returns to IDLE immediately. No partial IR or PC update survives.
- **Latency:** first `pm_rd` occurs on the first cycle after reset deasserts plus one (IDLE).
- **Throughput:** 4 cycles per instruction without stall, plus 1 per stall cycle.
- **Memory timing:** `pm_data` is sampled exactly one cycle after `pm_rd`. There is no memory wait state.
- **Output stability:** `IR` is stable from the end of LOAD until the end of the next LOAD. `pm_addr` is stable for the entire FETCH cycle.
- **Output style:** `pm_rd` and `ir_valid` are decoded from state, glitch-free (registered state, no input dependence).

## Structure
- **Shared package `seq_pkg`:**
  - state enum
  - branch group constant 5'b10000
  - op codes JMP/JZE/JNE/JCY/RET/BSR
  - NOP constant 24'h080000
- **Sub-module `return_stack`:** parameterised LIFO with push/pop, full/empty and error outputs, same `clk`/`reset`. The PC and FSM logic stay in `fetch_sequencer`.

## Test plan
- **Reset:** assert `reset` mid-EXEC. Expect `pm_rd`=0, IR=24'h080000, and `pm_addr`=000 while held. After release, expect `pm_rd` at cycle 2 with address 000.
- **Straight line:** three NOPs at 000..002. Expect `ir_valid` pulses 4 cycles apart and fetch addresses 000, 001, 002, 003.
- **Conditional branches:**
  - JZE 0x050 with z=1 → next fetch 050.
  - JZE 0x050 with z=0 at PC 010 → next fetch 011.
  - JNE and JCY behave symmetrically.
- **Subroutine:**
  - BSR 0x100 at PC 020 → fetch 100; RET at 100 → fetch 021.
  - Nested 8 deep returns correctly.
  - A 9th BSR sets `stack_err` and still jumps.
- **Underflow:** RET with an empty stack at PC 030 → `stack_err`=1, next fetch 031.
- **Wrap and stall:**
  - NOP at FFF → next fetch 000.
  - `stall`=1 for 3 cycles in EXEC of a JZE, with z toggling and z=1 on the release edge → exactly 7 cycles between `ir_valid` pulses, and the branch is taken.
